// File: rtl/legv8_instr_packer_if.sv
// Request/response bundle for the LEGv8 instruction packer: decoded fields in,
// packed word plus write address and range-error status out.
interface legv8_instr_packer_if #(
    parameter int ERR_W = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_fmt;
    logic [10:0]       in_opcode;
    logic [4:0]        in_rn;
    logic [4:0]        in_rd;
    logic [63:0]       in_imm;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [63:0]       out_addr;
    logic              out_sat;
    logic              err_pulse;
    logic [ERR_W-1:0]  err_count;

    modport master (
        output in_valid, in_fmt, in_opcode, in_rn, in_rd, in_imm, out_ready,
        input  in_ready, out_valid, out_instr, out_addr, out_sat, err_pulse, err_count
    );

    modport slave (
        input  in_valid, in_fmt, in_opcode, in_rn, in_rd, in_imm, out_ready,
        output in_ready, out_valid, out_instr, out_addr, out_sat, err_pulse, err_count
    );
endinterface

// File: rtl/legv8_instr_packer.sv
// Range-checks a signed immediate against its LEGv8 field width and packs D/CB/B/I words.
// Optional clamping of out-of-range immediates: define LEGV8_PACKER_IMM_SAT_EN.
module legv8_instr_packer #(
    parameter logic [63:0] BASE_ADDR = 64'h0,
    parameter int          ADDR_STEP = 4,
    parameter int          ERR_W     = 16
) (
    input logic                   clk,
    input logic                   reset,
    legv8_instr_packer_if.slave   bus
);

    typedef enum logic [1:0] {IDLE, CHECK, HOLD} state_t;

    state_t                state, state_nxt;
    logic [1:0]            fmt_p0;
    logic [10:0]           opcode_p0;
    logic [4:0]            rn_p0;
    logic [4:0]            rd_p0;
    logic signed [63:0]    imm_p0;
    logic signed [63:0]    imm_pack;
    logic [31:0]           instr_p1;
    logic [63:0]           addr_q;
    logic [ERR_W-1:0]      err_cnt;
    logic                  fits;
    logic                  ld_word;
    logic                  err_evt;
    logic                  fire;

    // The immediate fits when sign-extending its low N bits reproduces it.
    function automatic logic imm_fits(input logic [1:0] fmt, input logic signed [63:0] imm);
        logic signed [63:0] ext;
        case (fmt)
            2'd0:    ext = {{55{imm[8]}},  imm[8:0]};
            2'd1:    ext = {{45{imm[18]}}, imm[18:0]};
            2'd2:    ext = {{38{imm[25]}}, imm[25:0]};
            default: ext = {{52{imm[11]}}, imm[11:0]};
        endcase
        return ext == imm;
    endfunction

    function automatic logic signed [63:0] sat_imm(input logic [1:0] fmt,
                                                   input logic signed [63:0] imm);
        logic signed [63:0] lim;
        case (fmt)
            2'd0:    lim = 64'sd1 <<< 8;
            2'd1:    lim = 64'sd1 <<< 18;
            2'd2:    lim = 64'sd1 <<< 25;
            default: lim = 64'sd1 <<< 11;
        endcase
        if (imm_fits(fmt, imm))
            return imm;
        return imm[63] ? -lim : lim - 64'sd1;
    endfunction

    function automatic logic [31:0] pack_word(input logic [1:0] fmt, input logic [10:0] opcode,
                                              input logic [4:0] rn, input logic [4:0] rd,
                                              input logic signed [63:0] imm);
        case (fmt)
            2'd0:    return {opcode[10:0], imm[8:0], 2'b00, rn, rd};
            2'd1:    return {opcode[7:0], imm[18:0], rd};
            2'd2:    return {opcode[5:0], imm[25:0]};
            default: return {opcode[9:0], imm[11:0], rn, rd};
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ld_word   = 1'b0;
        err_evt   = 1'b0;
        fire      = 1'b0;
        fits      = imm_fits(fmt_p0, imm_p0);
`ifdef LEGV8_PACKER_IMM_SAT_EN
        imm_pack  = sat_imm(fmt_p0, imm_p0);
`else
        imm_pack  = imm_p0;
`endif
        case (state)
            IDLE: begin
                if (bus.in_valid)
                    state_nxt = CHECK;
            end
            CHECK: begin
                err_evt = !fits;
`ifdef LEGV8_PACKER_IMM_SAT_EN
                ld_word   = 1'b1;
                state_nxt = HOLD;
`else
                ld_word   = fits;
                state_nxt = fits ? HOLD : IDLE;
`endif
            end
            HOLD: begin
                if (bus.out_ready) begin
                    fire      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // p0: request capture, data only
    always_ff @(posedge clk) begin
        if (state == IDLE && bus.in_valid) begin
            fmt_p0    <= bus.in_fmt;
            opcode_p0 <= bus.in_opcode;
            rn_p0     <= bus.in_rn;
            rd_p0     <= bus.in_rd;
            imm_p0    <= bus.in_imm;
        end
    end

    // p1: packed word, address and error counter
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_p1 <= 32'h0;
            addr_q   <= BASE_ADDR;
            err_cnt  <= '0;
        end else begin
            if (ld_word)
                instr_p1 <= pack_word(fmt_p0, opcode_p0, rn_p0, rd_p0, imm_pack);
            if (fire)
                addr_q <= addr_q + 64'(ADDR_STEP);
            if (err_evt && err_cnt != {ERR_W{1'b1}})
                err_cnt <= err_cnt + 1'b1;
        end
    end

`ifdef LEGV8_PACKER_IMM_SAT_EN
    logic sat_p1;

    always_ff @(posedge clk) begin
        if (reset)
            sat_p1 <= 1'b0;
        else if (ld_word)
            sat_p1 <= !fits;
        else if (fire)
            sat_p1 <= 1'b0;
    end

    assign bus.out_sat = sat_p1;
`else
    assign bus.out_sat = 1'b0;
`endif

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == HOLD);
    assign bus.out_instr = instr_p1;
    assign bus.out_addr  = addr_q;
    assign bus.err_pulse = err_evt;
    assign bus.err_count = err_cnt;

endmodule

// File: tb/tb_legv8_instr_packer.sv
// Directed bench for legv8_instr_packer; honours LEGV8_PACKER_IMM_SAT_EN when defined.
module tb_legv8_instr_packer;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    logic [63:0] exp_addr;
    logic [15:0] exp_err;

`ifdef LEGV8_PACKER_IMM_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct packed {
        logic [1:0]  f;
        logic [10:0] op;
        logic [4:0]  rn;
        logic [4:0]  rd;
        logic [63:0] imm;
        logic [31:0] word;
        logic        fit;
    } vec_t;

    legv8_instr_packer_if #(.ERR_W(16)) bif ();

    legv8_instr_packer #(.BASE_ADDR(64'h0), .ADDR_STEP(4), .ERR_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] f, input logic [10:0] op, input logic [4:0] rn,
                        input logic [4:0] rd, input logic [63:0] imm);
        bif.in_valid  = 1'b1;
        bif.in_fmt    = f;
        bif.in_opcode = op;
        bif.in_rn     = rn;
        bif.in_rd     = rd;
        bif.in_imm    = imm;
        step();
        bif.in_valid  = 1'b0;
    endtask

    task automatic consume();
        bif.out_ready = 1'b1;
        step();
        bif.out_ready = 1'b0;
        exp_addr = exp_addr + 64'd4;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bif.in_valid = 1'b0;
        bif.out_ready = 1'b0;
        bif.in_fmt = 2'd0; bif.in_opcode = 11'h0; bif.in_rn = 5'd0; bif.in_rd = 5'd0;
        bif.in_imm = 64'h0;
        step();
        step();
        reset = 1'b0;
        exp_addr = 64'h0;
        exp_err  = 16'd0;
        checks++; if (bif.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bif.out_valid); end
        checks++; if (bif.out_instr !== 32'h0) begin errors++; $display("FAIL reset_out_instr got %h want 0", bif.out_instr); end
        checks++; if (bif.out_addr !== 64'h0) begin errors++; $display("FAIL reset_out_addr got %h want 0", bif.out_addr); end
        checks++; if (bif.out_sat !== 1'b0) begin errors++; $display("FAIL reset_out_sat got %b want 0", bif.out_sat); end
        checks++; if (bif.err_pulse !== 1'b0) begin errors++; $display("FAIL reset_err_pulse got %b want 0", bif.err_pulse); end
        checks++; if (bif.err_count !== 16'd0) begin errors++; $display("FAIL reset_err_count got %0d want 0", bif.err_count); end
        checks++; if (bif.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", bif.in_ready); end
    endtask

    task automatic test_d_fmt();
        send(2'd0, 11'h7C2, 5'd1, 5'd2, -64'sd8);
        checks++; if (bif.out_valid !== 1'b0) begin errors++; $display("FAIL d_early_valid got %b want 0", bif.out_valid); end
        checks++; if (bif.in_ready !== 1'b0) begin errors++; $display("FAIL d_check_in_ready got %b want 0", bif.in_ready); end
        step();
        checks++; if (bif.out_valid !== 1'b1) begin errors++; $display("FAIL d_valid got %b want 1", bif.out_valid); end
        checks++; if (bif.out_instr !== 32'hF85F8022) begin errors++; $display("FAIL d_instr got %h want F85F8022", bif.out_instr); end
        checks++; if (bif.out_addr !== exp_addr) begin errors++; $display("FAIL d_addr got %h want %h", bif.out_addr, exp_addr); end
        checks++; if (bif.out_sat !== 1'b0) begin errors++; $display("FAIL d_sat got %b want 0", bif.out_sat); end
        consume();
        checks++; if (bif.out_valid !== 1'b0) begin errors++; $display("FAIL d_after_valid got %b want 0", bif.out_valid); end
        checks++; if (bif.in_ready !== 1'b1) begin errors++; $display("FAIL d_after_in_ready got %b want 1", bif.in_ready); end
    endtask

    task automatic test_b_fmt();
        send(2'd2, 11'h005, 5'd0, 5'd0, -64'sd1);
        step();
        checks++; if (bif.out_valid !== 1'b1) begin errors++; $display("FAIL b_valid got %b want 1", bif.out_valid); end
        checks++; if (bif.out_instr !== 32'h17FFFFFF) begin errors++; $display("FAIL b_instr got %h want 17FFFFFF", bif.out_instr); end
        checks++; if (bif.out_addr !== 64'h4) begin errors++; $display("FAIL b_addr got %h want 4", bif.out_addr); end
        consume();
    endtask

    task automatic test_stall();
        send(2'd3, 11'h244, 5'd2, 5'd3, 64'd5);
        step();
        for (int i = 0; i < 5; i++) begin
            checks++; if (bif.out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d] got %b want 1", i, bif.out_valid); end
            checks++; if (bif.out_instr !== 32'h91001443) begin errors++; $display("FAIL stall_instr[%0d] got %h want 91001443", i, bif.out_instr); end
            checks++; if (bif.out_addr !== exp_addr) begin errors++; $display("FAIL stall_addr[%0d] got %h want %h", i, bif.out_addr, exp_addr); end
            checks++; if (bif.in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready[%0d] got %b want 0", i, bif.in_ready); end
            bif.in_valid  = 1'b1;
            bif.in_fmt    = 2'd2;
            bif.in_opcode = 11'h7FF;
            bif.in_imm    = 64'd99;
            step();
        end
        bif.in_valid = 1'b0;
        consume();
        checks++; if (bif.out_valid !== 1'b0) begin errors++; $display("FAIL stall_release_valid got %b want 0", bif.out_valid); end
        checks++; if (bif.out_addr !== exp_addr) begin errors++; $display("FAIL stall_release_addr got %h want %h", bif.out_addr, exp_addr); end
    endtask

    // Limits of each field, plus one beyond; rejected or clamped depending on build.
    task automatic test_range();
        vec_t vecs[10];
        vecs = '{
            '{2'd1, 11'h0B4, 5'd0, 5'd3, 64'd262144,          32'hB47FFFE3, 1'b0},
            '{2'd1, 11'h0B4, 5'd0, 5'd3, 64'd262143,          32'hB47FFFE3, 1'b1},
            '{2'd0, 11'h7C0, 5'd0, 5'd0, 64'd255,             32'hF80FF000, 1'b1},
            '{2'd0, 11'h7C0, 5'd0, 5'd0, -64'sd256,           32'hF8100000, 1'b1},
            '{2'd0, 11'h7C0, 5'd0, 5'd0, 64'd256,             32'hF80FF000, 1'b0},
            '{2'd0, 11'h7C0, 5'd0, 5'd0, -64'sd257,           32'hF8100000, 1'b0},
            '{2'd3, 11'h244, 5'd1, 5'd0, 64'd2048,            32'h911FFC20, 1'b0},
            '{2'd3, 11'h244, 5'd1, 5'd0, -64'sd2048,          32'h91200020, 1'b1},
            '{2'd2, 11'h005, 5'd0, 5'd0, 64'h1FFFFFF,         32'h15FFFFFF, 1'b1},
            '{2'd2, 11'h005, 5'd0, 5'd0, -64'sd33554433,      32'h16000000, 1'b0}
        };
        for (int i = 0; i < 10; i++) begin
            send(vecs[i].f, vecs[i].op, vecs[i].rn, vecs[i].rd, vecs[i].imm);
            checks++; if (bif.err_pulse !== !vecs[i].fit) begin errors++; $display("FAIL range_pulse[%0d] got %b want %b", i, bif.err_pulse, !vecs[i].fit); end
            step();
            if (!vecs[i].fit) exp_err = exp_err + 16'd1;
            checks++; if (bif.err_pulse !== 1'b0) begin errors++; $display("FAIL range_pulse_len[%0d] got %b want 0", i, bif.err_pulse); end
            checks++; if (bif.err_count !== exp_err) begin errors++; $display("FAIL range_err_count[%0d] got %0d want %0d", i, bif.err_count, exp_err); end
            if (vecs[i].fit || SAT) begin
                checks++; if (bif.out_valid !== 1'b1) begin errors++; $display("FAIL range_valid[%0d] got %b want 1", i, bif.out_valid); end
                checks++; if (bif.out_instr !== vecs[i].word) begin errors++; $display("FAIL range_instr[%0d] got %h want %h", i, bif.out_instr, vecs[i].word); end
                checks++; if (bif.out_addr !== exp_addr) begin errors++; $display("FAIL range_addr[%0d] got %h want %h", i, bif.out_addr, exp_addr); end
                checks++; if (bif.out_sat !== !vecs[i].fit) begin errors++; $display("FAIL range_sat[%0d] got %b want %b", i, bif.out_sat, !vecs[i].fit); end
                step();
                checks++; if (bif.out_sat !== !vecs[i].fit) begin errors++; $display("FAIL range_sat_hold[%0d] got %b want %b", i, bif.out_sat, !vecs[i].fit); end
                consume();
            end else begin
                checks++; if (bif.out_valid !== 1'b0) begin errors++; $display("FAIL range_reject_valid[%0d] got %b want 0", i, bif.out_valid); end
                checks++; if (bif.in_ready !== 1'b1) begin errors++; $display("FAIL range_reject_ready[%0d] got %b want 1", i, bif.in_ready); end
                checks++; if (bif.out_addr !== exp_addr) begin errors++; $display("FAIL range_reject_addr[%0d] got %h want %h", i, bif.out_addr, exp_addr); end
                checks++; if (bif.out_sat !== 1'b0) begin errors++; $display("FAIL range_reject_sat[%0d] got %b want 0", i, bif.out_sat); end
            end
        end
    endtask

    task automatic test_reset_in_hold();
        send(2'd0, 11'h7C2, 5'd1, 5'd2, -64'sd8);
        step();
        checks++; if (bif.out_valid !== 1'b1) begin errors++; $display("FAIL rh_pre_valid got %b want 1", bif.out_valid); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        exp_addr = 64'h0;
        exp_err  = 16'd0;
        checks++; if (bif.out_valid !== 1'b0) begin errors++; $display("FAIL rh_valid got %b want 0", bif.out_valid); end
        checks++; if (bif.out_addr !== 64'h0) begin errors++; $display("FAIL rh_addr got %h want 0", bif.out_addr); end
        checks++; if (bif.err_count !== 16'd0) begin errors++; $display("FAIL rh_err_count got %0d want 0", bif.err_count); end
        checks++; if (bif.out_instr !== 32'h0) begin errors++; $display("FAIL rh_instr got %h want 0", bif.out_instr); end
        checks++; if (bif.in_ready !== 1'b1) begin errors++; $display("FAIL rh_in_ready got %b want 1", bif.in_ready); end
        send(2'd2, 11'h005, 5'd0, 5'd0, -64'sd1);
        step();
        checks++; if (bif.out_instr !== 32'h17FFFFFF) begin errors++; $display("FAIL rh_new_instr got %h want 17FFFFFF", bif.out_instr); end
        checks++; if (bif.out_addr !== 64'h0) begin errors++; $display("FAIL rh_new_addr got %h want 0", bif.out_addr); end
        consume();
        checks++; if (bif.out_addr !== 64'h4) begin errors++; $display("FAIL rh_next_addr got %h want 4", bif.out_addr); end
    endtask

    initial begin
        test_reset();
        test_d_fmt();
        test_b_fmt();
        test_stall();
        test_range();
        test_reset_in_hold();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
